// File: rtl/conv_tree_frame_scheduler.sv
// conv_tree_frame_scheduler: round-robin frame scheduler feeding a shared parallel-to-serial tree.
// Optional idle fill via `define CONV_SCHED_IDLE_FILL_EN (drives IDLE_WORD while idle).
module conv_tree_frame_scheduler #(
    parameter int INPUTS_NUM = 256,
    parameter int NUM_REQ = 4,
    parameter int OUT_LATENCY = 8,
    parameter logic [INPUTS_NUM-1:0] IDLE_WORD = '0,
    localparam int BW = $clog2(INPUTS_NUM),
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          ENABLE,
    input  logic [NUM_REQ-1:0]            REQ_VALID,
    input  logic [NUM_REQ*INPUTS_NUM-1:0] REQ_DATA,
    output logic [NUM_REQ-1:0]            REQ_READY,
    output logic [INPUTS_NUM-1:0]         PAR_OUT,
    output logic                          FRAME_START,
    output logic [BW-1:0]                 BIT_CNT,
    output logic [GW-1:0]                 GRANT_ID,
    output logic                          BUSY,
    output logic                          SER_FRAME_START
);
`ifdef CONV_SCHED_IDLE_FILL_EN
    localparam logic [INPUTS_NUM-1:0] FILL_WORD = IDLE_WORD;
`else
    localparam logic [INPUTS_NUM-1:0] FILL_WORD = IDLE_WORD & '0;
`endif
    typedef enum logic {S_IDLE, S_RUN} state_t;
    state_t state, state_nxt;
    logic [GW-1:0] ptr, grant;
    logic [OUT_LATENCY-1:0] pipe;
    logic found, last, accept;
    int idx;
    assign last = BIT_CNT == BW'(INPUTS_NUM - 1);
    assign accept = RESET && ENABLE && |REQ_VALID && (state == S_IDLE || last);
    assign SER_FRAME_START = pipe[OUT_LATENCY-1];
    // first valid requester at or after the pointer, wrapping
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && REQ_VALID[idx]) begin
                found = 1'b1;
                grant = GW'(idx);
            end
        end
    end
    always_ff @(posedge CLK) begin
        if (!RESET) state <= S_IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = accept ? S_RUN : (state == S_RUN && last) ? S_IDLE : state;
    end
    always_comb begin
        BUSY = state == S_RUN;
        REQ_READY = accept ? NUM_REQ'(1) << grant : '0;
    end
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            PAR_OUT <= FILL_WORD;
            BIT_CNT <= '0;
            GRANT_ID <= '0;
            ptr <= '0;
            FRAME_START <= 1'b0;
            pipe <= '0;
        end else begin
            FRAME_START <= accept;
            pipe <= (pipe << 1) | OUT_LATENCY'(FRAME_START);
            if (accept) begin
                PAR_OUT <= REQ_DATA[grant*INPUTS_NUM +: INPUTS_NUM];
                GRANT_ID <= grant;
                BIT_CNT <= '0;
                ptr <= (grant == GW'(NUM_REQ - 1)) ? '0 : grant + GW'(1);
            end else if (state == S_RUN) begin
                BIT_CNT <= last ? '0 : BIT_CNT + BW'(1);
`ifdef CONV_SCHED_IDLE_FILL_EN
                if (last) PAR_OUT <= IDLE_WORD;
`endif
            end
        end
    end
endmodule

// File: tb/tb_conv_tree_frame_scheduler.sv
// tb_conv_tree_frame_scheduler: directed checks of arbitration, framing, idle, enable and reset behaviour.
module tb_conv_tree_frame_scheduler;
    logic CLK = 1'b0;
    logic RESET = 1'b0;
    logic ENABLE = 1'b0;
    logic [2:0] REQ_VALID = '0;
    logic [23:0] REQ_DATA = '0;
    logic [2:0] REQ_READY;
    logic [7:0] PAR_OUT;
    logic FRAME_START;
    logic [2:0] BIT_CNT;
    logic [1:0] GRANT_ID;
    logic BUSY;
    logic SER_FRAME_START;
    int n_chk = 0;
    int n_fail = 0;

    conv_tree_frame_scheduler #(.INPUTS_NUM(8), .NUM_REQ(3), .OUT_LATENCY(3), .IDLE_WORD(8'h00)) dut (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .REQ_VALID(REQ_VALID), .REQ_DATA(REQ_DATA),
        .REQ_READY(REQ_READY), .PAR_OUT(PAR_OUT), .FRAME_START(FRAME_START), .BIT_CNT(BIT_CNT),
        .GRANT_ID(GRANT_ID), .BUSY(BUSY), .SER_FRAME_START(SER_FRAME_START)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic check_start(input string tag, input logic [7:0] par, input logic [1:0] gid);
        check({tag, "_par"}, PAR_OUT, par);
        check({tag, "_gid"}, GRANT_ID, gid);
        check({tag, "_fs"}, FRAME_START, 1);
        check({tag, "_cnt"}, BIT_CNT, 0);
        check({tag, "_busy"}, BUSY, 1);
    endtask

    initial begin
        logic [7:0] par_idle;
        logic [7:0] frame_par [4];
        logic [1:0] frame_gid [4];
        frame_par = '{8'h11, 8'h22, 8'h33, 8'h11};
        frame_gid = '{2'd0, 2'd1, 2'd2, 2'd0};
        // reset state
        step(2);
        check("rst_par", PAR_OUT, 0);
        check("rst_cnt", BIT_CNT, 0);
        check("rst_gid", GRANT_ID, 0);
        check("rst_busy", BUSY, 0);
        check("rst_fs", FRAME_START, 0);
        check("rst_ser", SER_FRAME_START, 0);
        // 1: single requester 1
        RESET = 1'b1;
        ENABLE = 1'b1;
        REQ_VALID = 3'b010;
        REQ_DATA = 24'h00A500;
        #1 check("t1_ready", REQ_READY, 3'b010);
        step(1);
        check_start("t1", 8'hA5, 1);
        check("t1_ready_mid", REQ_READY, 0);
        step(2);
        check("t1_ser_early", SER_FRAME_START, 0);
        step(1);
        check("t1_ser", SER_FRAME_START, 1);
        check("t1_fs_mid", FRAME_START, 0);
        REQ_VALID = 3'b000;
        step(4);
        check("t1_cnt7", BIT_CNT, 7);
        check("t1_busy7", BUSY, 1);
        check("t1_par7", PAR_OUT, 8'hA5);
        // 3: return to idle
        step(1);
        check("t3_busy", BUSY, 0);
        check("t3_cnt", BIT_CNT, 0);
`ifdef CONV_SCHED_IDLE_FILL_EN
        par_idle = 8'h00;
`else
        par_idle = 8'hA5;
`endif
        check("t3_par", PAR_OUT, par_idle);
        check("t3_fs", FRAME_START, 0);
        // 2: all valid from pointer 0, back-to-back
        RESET = 1'b0;
        step(1);
        RESET = 1'b1;
        REQ_VALID = 3'b111;
        REQ_DATA = 24'h332211;
        for (int f = 0; f < 4; f++) begin
            #1 check($sformatf("t2_ready%0d", f), REQ_READY, 3'b001 << frame_gid[f]);
            step(1);
            check_start($sformatf("t2_f%0d", f), frame_par[f], frame_gid[f]);
            if (f < 3) step(7);
        end
        // 4: enable drop mid-frame
        step(3);
        check("t4_cnt3", BIT_CNT, 3);
        ENABLE = 1'b0;
        step(4);
        check("t4_cnt7", BIT_CNT, 7);
        check("t4_ready7", REQ_READY, 0);
        step(1);
        check("t4_busy", BUSY, 0);
        check("t4_fs", FRAME_START, 0);
        ENABLE = 1'b1;
        #1 check("t4_ready", REQ_READY, 3'b010);
        step(1);
        check_start("t4", 8'h22, 1);
        // 5: reset mid-frame
        step(4);
        check("t5_cnt4", BIT_CNT, 4);
        RESET = 1'b0;
        #1 check("t5_ready_rst", REQ_READY, 0);
        step(1);
        check("t5_par", PAR_OUT, 0);
        check("t5_cnt", BIT_CNT, 0);
        check("t5_gid", GRANT_ID, 0);
        check("t5_busy", BUSY, 0);
        check("t5_ser", SER_FRAME_START, 0);
        RESET = 1'b1;
        #1 check("t5_ready_ptr", REQ_READY, 3'b001);
        // 6: late-rising valid joins the boundary
        step(1);
        check_start("t6_f0", 8'h11, 0);
        REQ_VALID = 3'b001;
        step(3);
        check("t6_ser", SER_FRAME_START, 1);
        step(4);
        check("t6_cnt7", BIT_CNT, 7);
        REQ_VALID = 3'b100;
        #1 check("t6_ready", REQ_READY, 3'b100);
        step(1);
        check_start("t6_f1", 8'h33, 2);
        REQ_VALID = 3'b000;
        step(8);
        check("t6_idle", BUSY, 0);
`ifdef CONV_SCHED_IDLE_FILL_EN
        par_idle = 8'h00;
`else
        par_idle = 8'h33;
`endif
        check("t6_par_idle", PAR_OUT, par_idle);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
